// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } state_t;

  localparam int BCD_W    = 4;
  localparam int MAX_NDIG = 8;
  localparam logic [MAX_NDIG-1:0] ANODE_ALL_OFF = '1;

  // Active-low anode pattern: all dark unless lit, then only digit idx pulled low.
  function automatic logic [MAX_NDIG-1:0] anode_sel(input logic lit, input int unsigned idx);
    logic [MAX_NDIG-1:0] a;
    a = ANODE_ALL_OFF;
    if (lit) a[idx[2:0]] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot phase counter: counts up to the supplied terminal value, then restarts at 0.
module seg_slot_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] last,
  output logic         tc,
  output logic         first
);

  logic [W-1:0] cnt_reg;

  assign tc    = (cnt_reg == last);
  assign first = (cnt_reg == '0);

  // Terminal count coincides with every state change, so it doubles as the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt_reg <= '0;
    else if (tc) cnt_reg <= '0;
    else         cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with double-buffered digits and dead-time gaps.
// Optional build macro SEG_SCAN_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int ON_CYC  = 50000,
  parameter int GAP_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BCD_W*NDIG-1:0] digits_i,
  input  logic                  load_i,
  input  logic [NDIG-1:0]       blank_i,
  output logic [BCD_W-1:0]      dec_in_o,
  output logic                  dec_en_o,
  output logic [NDIG-1:0]       anode_o,
  output logic                  frame_o
);

  localparam int CNT_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(NDIG);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  state_t                  state_reg, state_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [BCD_W*NDIG-1:0]   shadow_reg, active_reg;
  logic                    pending_reg;
  logic [CW-1:0]           last;
  logic                    tc, first, wrap;
  logic [NDIG-1:0]         lz_mask;

  logic [BCD_W-1:0]        dec_in_next;
  logic                    dec_en_next, frame_next, lit;
  logic [NDIG-1:0]         anode_next;
  logic [MAX_NDIG-1:0]     sel_wide;

  assign last = (state_reg == S_ON) ? ON_LAST : GAP_LAST;

  seg_slot_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .last  (last),
    .tc    (tc),
    .first (first)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_GAP;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (tc) begin
      case (state_reg)
        S_GAP: state_next = S_ON;
        S_ON: begin
          state_next = S_GAP;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        default: state_next = S_GAP;
      endcase
    end
  end

  // Frame boundary: last ON cycle of the highest digit.
  assign wrap = (state_reg == S_ON) && tc && (idx_reg == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg  <= '0;
      active_reg  <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (load_i) shadow_reg <= digits_i;
      if (wrap) begin
        pending_reg <= 1'b0;
        if (load_i)           active_reg <= digits_i;
        else if (pending_reg) active_reg <= shadow_reg;
      end else if (load_i) begin
        pending_reg <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  // Active digits only change at the frame boundary, so deriving the mask from them
  // is equivalent to evaluating it once at commit.
  always_comb begin
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (active_reg[BCD_W*k +: BCD_W] == '0);
      lz_mask[k] = upper_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    lit         = (state_reg == S_ON) && !(blank_i[idx_reg] | lz_mask[idx_reg]);
    sel_wide    = anode_sel(lit, 32'(idx_reg));
    anode_next  = sel_wide[NDIG-1:0];
    dec_en_next = lit;
    dec_in_next = (state_reg == S_ON) ? active_reg[BCD_W*idx_reg +: BCD_W] : dec_in_o;
    frame_next  = (state_reg == S_ON) && (idx_reg == '0) && first;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_o  <= '1;
      dec_en_o <= 1'b0;
      dec_in_o <= '0;
      frame_o  <= 1'b0;
    end else begin
      anode_o  <= anode_next;
      dec_en_o <= dec_en_next;
      dec_in_o <= dec_in_next;
      frame_o  <= frame_next;
    end
  end

endmodule
